// File: rtl/mdu_param.sv
// Parametrised multiply/divide unit holding the HI/LO pair; MULT/DIV run for a fixed latency.
// Define MDU_MADD_EN to add the MADD/MADDU multiply-accumulate ops.
module mdu_param #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] num_a,
    input  logic [WIDTH-1:0] num_b,
    input  logic             cancel,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;

    logic               is_long_s;
    logic [CNT_W-1:0]   lat_s;
    logic [2*WIDTH-1:0] commit_s;

    // Full-width product; operands are sign- or zero-extended so a modulo-2^(2W) multiply is exact.
    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic             sgn);
        logic [2*WIDTH-1:0] ax;
        logic [2*WIDTH-1:0] bx;
        ax = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        bx = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}; magnitude division with sign fix-up makes MIN/-1 wrap to MIN, rem 0.
    function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic             sgn);
        logic             neg_a;
        logic             neg_b;
        logic [WIDTH-1:0] ua;
        logic [WIDTH-1:0] ub;
        logic [WIDTH-1:0] uq;
        logic [WIDTH-1:0] ur;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        neg_a = sgn & a[WIDTH-1];
        neg_b = sgn & b[WIDTH-1];
        ua    = neg_a ? -a : a;
        ub    = neg_b ? -b : b;
        if (b == ZERO_W) begin
            q = ONES_W;
            r = a;
        end else begin
            uq = ua / ub;
            ur = ua % ub;
            q  = (neg_a ^ neg_b) ? -uq : uq;
            r  = neg_a ? -ur : ur;
        end
        return {r, q};
    endfunction

    // Classify the presented op as multi-cycle and pick its latency.
    always_comb begin
        is_long_s = 1'b0;
        lat_s     = CNT_W'(MUL_LAT);
        case (op)
            OP_MULT, OP_MULTU: begin
                is_long_s = 1'b1;
                lat_s     = CNT_W'(MUL_LAT);
            end
            OP_DIV, OP_DIVU: begin
                is_long_s = 1'b1;
                lat_s     = CNT_W'(DIV_LAT);
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                is_long_s = 1'b1;
                lat_s     = CNT_W'(MUL_LAT);
            end
`endif
            default: begin
                is_long_s = 1'b0;
                lat_s     = CNT_W'(MUL_LAT);
            end
        endcase
    end

    // Value written to {hi,lo} when the latched op commits; accumulate uses hi/lo as of commit.
    always_comb begin
        commit_s = {hi_q, lo_q};
        case (op_q)
            OP_MULT:  commit_s = mul_full(a_q, b_q, 1'b1);
            OP_MULTU: commit_s = mul_full(a_q, b_q, 1'b0);
            OP_DIV:   commit_s = div_full(a_q, b_q, 1'b1);
            OP_DIVU:  commit_s = div_full(a_q, b_q, 1'b0);
`ifdef MDU_MADD_EN
            OP_MADD:  commit_s = {hi_q, lo_q} + mul_full(a_q, b_q, 1'b1);
            OP_MADDU: commit_s = {hi_q, lo_q} + mul_full(a_q, b_q, 1'b0);
`endif
            default:  commit_s = {hi_q, lo_q};
        endcase
    end

    // Next-state logic for the IDLE/BUSY sequencer and the HI/LO pair.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    if (is_long_s) begin
                        a_d     = num_a;
                        b_d     = num_b;
                        op_d    = op;
                        cnt_d   = lat_s;
                        state_d = S_BUSY;
                    end else if (op == OP_MTHI) begin
                        hi_d = num_a;
                    end else if (op == OP_MTLO) begin
                        lo_d = num_a;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                // Cancel wins over the final-cycle commit so a flushed op never lands.
                if (cancel) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    {hi_d, lo_d} = commit_s;
                    cnt_d        = {CNT_W{1'b0}};
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_BUSY);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            a_q     <= ZERO_W;
            b_q     <= ZERO_W;
            op_q    <= 4'd0;
            hi_q    <= ZERO_W;
            lo_q    <= ZERO_W;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    // Read port for MFHI/MFLO.
    always_comb begin
        if (op == OP_MFHI) begin
            result = hi_q;
        end else if (op == OP_MFLO) begin
            result = lo_q;
        end else begin
            result = ZERO_W;
        end
    end

    assign busy      = busy_q;
    assign stall_req = busy_q | (start & is_long_s);
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_param.sv
// Self-checking bench for mdu_param: table-driven mult/div vectors with a scoreboard, plus
// hand-written reset, move, cancel and optional-op sequences.
module tb_mdu_param;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cancel;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    mdu_param #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(rst_n), .start(start), .op(op_i), .num_a(a_i), .num_b(b_i),
        .cancel(cancel), .busy(busy), .stall_req(stall_req), .result(result), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    localparam int NV = 11;
    vec_t vecs[NV];
    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name);
        @(negedge clk);
        start = 1'b1;
        op_i  = op;
        a_i   = a;
        b_i   = b;
        #1;
        check({name, "_stall_req"}, 64'(stall_req), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_i  = OP_NONE;
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] val);
        @(negedge clk);
        start = 1'b1;
        op_i  = op;
        a_i   = val;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_i  = OP_NONE;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int   cyc;
        exp_t e;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT, "mult_neg2x3"};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MUL_LAT, "multu_fffe_x3"};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT, "div_m7_2"};
        vecs[3]  = '{OP_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, DIV_LAT, "divu_by0"};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT, "div_ovf"};
        vecs[5]  = '{OP_DIV,   32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, DIV_LAT, "div_by0"};
        vecs[6]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT, "multu_max"};
        vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT, "mult_min_sq"};
        vecs[8]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, DIV_LAT, "divu_100_7"};
        vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT, "div_7_m2"};
        vecs[10] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, DIV_LAT, "div_m8_m3"};

        rst_n  = 1'b0;
        start  = 1'b0;
        op_i   = OP_NONE;
        a_i    = '0;
        b_i    = '0;
        cancel = 1'b0;
        #1;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].name);
            sb_q.push_back('{vecs[i].exp_hi, vecs[i].exp_lo});
            wait_idle(cyc);
            check({vecs[i].name, "_busy_cycles"}, 64'(cyc), 64'(vecs[i].lat));
            e = sb_q.pop_front();
            check({vecs[i].name, "_hi"}, 64'(hi), 64'(e.hi));
            check({vecs[i].name, "_lo"}, 64'(lo), 64'(e.lo));
        end

        // Asynchronous reset in the middle of a multiply.
        issue(OP_MULT, 32'd3, 32'd3, "rst_mid_mult");
        @(posedge clk);
        #1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op_i  = OP_MFHI;
        #1;
        check("rst_mfhi_result", 64'(result), 64'd0);
        op_i = OP_NONE;
        repeat (MUL_LAT + 1) @(posedge clk);
        #1;
        check("rst_no_late_commit_lo", 64'(lo), 64'd0);

        // Moves and reads.
        move_to(OP_MTHI, 32'h1234);
        @(negedge clk);
        start = 1'b1;
        op_i  = OP_MFHI;
        #1;
        check("mfhi_after_mthi", 64'(result), 64'h1234);
        start = 1'b0;
        op_i  = OP_NONE;
        move_to(OP_MTLO, 32'h5678);
        @(negedge clk);
        op_i = OP_MFLO;
        #1;
        check("mflo_after_mtlo", 64'(result), 64'h5678);
        op_i = OP_NONE;
        #1;
        check("result_idle_zero", 64'(result), 64'd0);

        // MTLO presented while busy is ignored; only the product lands.
        issue(OP_MULTU, 32'd2, 32'd3, "mtlo_in_busy");
        @(negedge clk);
        start = 1'b1;
        op_i  = OP_MTLO;
        a_i   = 32'hDEAD;
        #1;
        check("busy_stall_req", 64'(stall_req), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_i  = OP_NONE;
        wait_idle(cyc);
        check("mtlo_in_busy_hi", 64'(hi), 64'd0);
        check("mtlo_in_busy_lo", 64'(lo), 64'd6);

        // Cancel on the third busy cycle.
        move_to(OP_MTHI, 32'hAAAA);
        move_to(OP_MTLO, 32'hBBBB);
        issue(OP_MULT, 32'd5, 32'd5, "cancel3");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel3_busy", 64'(busy), 64'd0);
        check("cancel3_hi", 64'(hi), 64'hAAAA);
        check("cancel3_lo", 64'(lo), 64'hBBBB);
        repeat (MUL_LAT + 1) @(posedge clk);
        #1;
        check("cancel3_lo_later", 64'(lo), 64'hBBBB);

        // Cancel coincident with the final (commit) cycle.
        issue(OP_MULT, 32'd5, 32'd5, "cancel_commit");
        repeat (MUL_LAT - 1) begin
            @(posedge clk);
            #1;
        end
        check("cancel_commit_still_busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_commit_busy", 64'(busy), 64'd0);
        check("cancel_commit_hi", 64'(hi), 64'hAAAA);
        check("cancel_commit_lo", 64'(lo), 64'hBBBB);

        // Cancel in IDLE suppresses a start.
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        op_i   = OP_MTHI;
        a_i    = 32'h7777;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        op_i   = OP_NONE;
        check("cancel_idle_hi", 64'(hi), 64'hAAAA);

        issue(OP_MULTU, 32'd5, 32'd5, "recover");
        wait_idle(cyc);
        check("recover_cycles", 64'(cyc), 64'(MUL_LAT));
        check("recover_lo", 64'(lo), 64'd25);

`ifdef MDU_MADD_EN
        move_to(OP_MTHI, 32'h0);
        move_to(OP_MTLO, 32'hFFFFFFFF);
        issue(OP_MADDU, 32'd1, 32'd1, "maddu");
        wait_idle(cyc);
        check("maddu_cycles", 64'(cyc), 64'(MUL_LAT));
        check("maddu_hi", 64'(hi), 64'd1);
        check("maddu_lo", 64'(lo), 64'd0);
`else
        @(negedge clk);
        start = 1'b1;
        op_i  = 4'd9;
        a_i   = 32'd5;
        b_i   = 32'd5;
        #1;
        check("op9_stall_req", 64'(stall_req), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_i  = OP_NONE;
        check("op9_busy", 64'(busy), 64'd0);
        check("op9_hi", 64'(hi), 64'd0);
        check("op9_lo", 64'(lo), 64'd25);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
